// File: rtl/neural_layer_engine.sv
// Dense-layer engine: y[j] = act(sum_i W[j][i]*x[i] + b[j]) over a shared
// word-addressed memory with one-cycle read latency. Results are written back
// to the same memory, and the location/size of the last finished layer is
// reported so a sequencer can chain layers.
module neural_layer_engine #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic [CNT_W-1:0]  cfg_n_in,
  input  logic [CNT_W-1:0]  cfg_n_out,
  input  logic              cfg_relu,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] result_base_address,
  output logic [CNT_W-1:0]  result_word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_X, S_RD_W, S_MAC, S_RD_B, S_ADD_B, S_WR, S_FIN
  } state_t;

  // Saturation bounds expressed at accumulator width for signed compares.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] WORD_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] WORD_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t state_reg, state_next;

  logic [ADDR_W-1:0]        in_base_reg;
  logic [ADDR_W-1:0]        out_base_reg;
  logic [ADDR_W-1:0]        row_addr_reg;   // w_base + j*(n_in+1), kept incrementally
  logic [CNT_W-1:0]         n_in_reg;
  logic [CNT_W-1:0]         n_out_reg;
  logic                     relu_reg;
  logic [CNT_W-1:0]         i_reg;
  logic [CNT_W-1:0]         j_reg;
  logic signed [DATA_W-1:0] x_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic [ADDR_W-1:0]        result_base_reg;
  logic [CNT_W-1:0]         result_count_reg;

  logic [CNT_W-1:0]           i_inc;
  logic [CNT_W-1:0]           j_inc;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    acc_shift;
  logic [DATA_W-1:0]          y_sat;
  logic [DATA_W-1:0]          y_word;

  assign i_inc = i_reg + CNT_W'(1);
  assign j_inc = j_reg + CNT_W'(1);

  // Arithmetic: full-precision product, bias aligned to product scale, and
  // the rounded-down / saturated / optionally rectified output word.
  always_comb begin
    prod      = (2*DATA_W)'(x_reg) * (2*DATA_W)'($signed(mem_rd_data));
    prod_ext  = ACC_W'(prod);
    bias_ext  = ACC_W'($signed(mem_rd_data)) <<< FRAC_W;
    acc_shift = acc_reg >>> FRAC_W;
    if (acc_shift > SAT_MAX) begin
      y_sat = WORD_MAX;
    end else if (acc_shift < SAT_MIN) begin
      y_sat = WORD_MIN;
    end else begin
      y_sat = acc_shift[DATA_W-1:0];
    end
    y_word = (relu_reg && y_sat[DATA_W-1]) ? '0 : y_sat;
  end

  // State register; reset abandons any layer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and memory/handshake outputs; strobes are exclusive by state.
  always_comb begin
    state_next  = state_reg;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    done        = 1'b0;
    busy        = (state_reg != S_IDLE) && (state_reg != S_FIN);
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (cfg_n_out == '0)     state_next = S_FIN;
          else if (cfg_n_in == '0) state_next = S_RD_B;
          else                     state_next = S_RD_X;
        end
      end
      S_RD_X: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = in_base_reg + ADDR_W'(i_reg);
        state_next  = S_RD_W;
      end
      S_RD_W: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = row_addr_reg + ADDR_W'(i_reg);
        state_next  = S_MAC;
      end
      S_MAC: begin
        state_next = (i_inc == n_in_reg) ? S_RD_B : S_RD_X;
      end
      S_RD_B: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = row_addr_reg + ADDR_W'(n_in_reg);
        state_next  = S_ADD_B;
      end
      S_ADD_B: begin
        state_next = S_WR;
      end
      S_WR: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = out_base_reg + ADDR_W'(j_reg);
        mem_wr_data = y_word;
        if (j_inc == n_out_reg)   state_next = S_FIN;
        else if (n_in_reg == '0)  state_next = S_RD_B;
        else                      state_next = S_RD_X;
      end
      S_FIN: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: config capture, counters, row pointer, accumulator, results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_base_reg      <= '0;
      out_base_reg     <= '0;
      row_addr_reg     <= '0;
      n_in_reg         <= '0;
      n_out_reg        <= '0;
      relu_reg         <= 1'b0;
      i_reg            <= '0;
      j_reg            <= '0;
      x_reg            <= '0;
      acc_reg          <= '0;
      result_base_reg  <= '0;
      result_count_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            in_base_reg  <= cfg_in_base;
            out_base_reg <= cfg_out_base;
            row_addr_reg <= cfg_w_base;
            n_in_reg     <= cfg_n_in;
            n_out_reg    <= cfg_n_out;
            relu_reg     <= cfg_relu;
            i_reg        <= '0;
            j_reg        <= '0;
            acc_reg      <= '0;
          end
        end
        S_RD_W: x_reg <= $signed(mem_rd_data);
        S_MAC: begin
          acc_reg <= acc_reg + prod_ext;
          i_reg   <= i_inc;
        end
        S_ADD_B: acc_reg <= acc_reg + bias_ext;
        S_WR: begin
          acc_reg      <= '0;
          i_reg        <= '0;
          j_reg        <= j_inc;
          row_addr_reg <= row_addr_reg + ADDR_W'(n_in_reg) + ADDR_W'(1);
        end
        S_FIN: begin
          result_base_reg  <= out_base_reg;
          result_count_reg <= n_out_reg;
        end
        default: ;
      endcase
    end
  end

  assign result_base_address = result_base_reg;
  assign result_word_count   = result_count_reg;

endmodule
